// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and defaults for the program loader and its RAM.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int DEF_MEM_DEPTH = 32;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader (SYNC, LEN, data, CSUM) driving a RAM byte-write port.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       restart,
  output logic [7:0] mem_in,
  output logic [7:0] data_in,
  output logic       we,
  output logic [5:0] bytes_loaded,
  output logic       load_done,
  output logic       load_err,
  output logic       cpu_run
);
  localparam logic [7:0] MAX_LEN = 8'(MEM_DEPTH);
  state_t r_state, w_next;
  logic [7:0] r_len, r_sum;
  logic w_fire, w_bad_len, w_last;
  assign w_fire = in_valid && in_ready;
  assign w_bad_len = (in_byte == 8'd0) || (in_byte > MAX_LEN);
  assign w_last = ({2'b00, bytes_loaded} + 8'd1) == r_len;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = (w_fire && in_byte == SYNC_BYTE) ? LEN : IDLE;
      LEN:  w_next = w_fire ? (w_bad_len ? ERR : DATA) : LEN;
      DATA: w_next = (w_fire && w_last) ? CSUM : DATA;
      CSUM: w_next = w_fire ? ((in_byte == r_sum) ? DONE : ERR) : CSUM;
      default: w_next = restart ? IDLE : r_state;
    endcase
  end
  always_comb in_ready = (r_state != DONE) && (r_state != ERR);
  // Flags follow the state being entered, so they are high exactly while in DONE/ERR.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_in <= 8'd0;
      data_in <= 8'd0;
      we <= 1'b0;
      bytes_loaded <= 6'd0;
      load_done <= 1'b0;
      load_err <= 1'b0;
      cpu_run <= 1'b0;
      r_len <= 8'd0;
      r_sum <= 8'd0;
    end else begin
      we <= w_fire && r_state == DATA;
      load_done <= w_next == DONE;
      cpu_run <= w_next == DONE;
      load_err <= w_next == ERR;
      if (w_fire && r_state == IDLE && in_byte == SYNC_BYTE) begin
        r_sum <= 8'd0;
        bytes_loaded <= 6'd0;
      end
      if (w_fire && r_state == LEN && !w_bad_len) r_len <= in_byte;
      if (w_fire && r_state == DATA) begin
        mem_in <= BASE_ADDR + {2'b00, bytes_loaded};
        data_in <= in_byte;
        r_sum <= r_sum + in_byte;
        bytes_loaded <= bytes_loaded + 6'd1;
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench driving two loaders (base 0x00 and 0x10) with the same stream.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic restart = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic a_ready, a_we, a_done, a_err, a_run;
  logic b_ready, b_we, b_done, b_err, b_run;
  logic [7:0] a_mem, a_data, b_mem, b_data;
  logic [5:0] a_bl, b_bl;
  int checks = 0;
  int errors = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] ea, eb;
  logic [7:0] fd[$];

  prog_loader u_a (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(a_ready),
    .restart(restart), .mem_in(a_mem), .data_in(a_data), .we(a_we), .bytes_loaded(a_bl),
    .load_done(a_done), .load_err(a_err), .cpu_run(a_run)
  );
  prog_loader #(.BASE_ADDR(8'h10)) u_b (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(b_ready),
    .restart(restart), .mem_in(b_mem), .data_in(b_data), .we(b_we), .bytes_loaded(b_bl),
    .load_done(b_done), .load_err(b_err), .cpu_run(b_run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (a_we === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL write_a unexpected got addr %0h data %0h required none", a_mem, a_data);
      end else begin
        ea = qa.pop_front();
        if ({a_mem, a_data} !== ea) begin
          errors++;
          $display("FAIL write_a got %0h required %0h", {a_mem, a_data}, ea);
        end
      end
    end

  always @(negedge clk)
    if (b_we === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL write_b unexpected got addr %0h data %0h required none", b_mem, b_data);
      end else begin
        eb = qb.pop_front();
        if ({b_mem, b_data} !== eb) begin
          errors++;
          $display("FAIL write_b got %0h required %0h", {b_mem, b_data}, eb);
        end
      end
    end

  task automatic flags(input string n, input bit d, input bit e, input logic [5:0] bl, input bit rdy);
    chk({n, "_a"}, {22'd0, a_done, a_err, a_run, a_bl, a_ready}, {22'd0, d, e, d, bl, rdy});
    chk({n, "_b"}, {22'd0, b_done, b_err, b_run, b_bl, b_ready}, {22'd0, d, e, d, bl, rdy});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    in_byte = b;
    in_valid = 1'b1;
    chk("ready_on_send", {30'd0, a_ready, b_ready}, 32'd3);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Reference: a legal frame writes byte i at base+i; DONE iff the checksum equals the byte sum mod 256.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] csum, input int lo, input int hi);
    int s;
    bit legal, ok;
    s = 0;
    legal = (len != 8'd0) && (len <= 8'd32);
    put(8'hA5);
    idle($urandom_range(hi, lo));
    put(len);
    if (legal) begin
      foreach (fd[i]) begin
        idle($urandom_range(hi, lo));
        qa.push_back({8'(i), fd[i]});
        qb.push_back({8'h10 + 8'(i), fd[i]});
        s += int'(fd[i]);
        put(fd[i]);
      end
      idle($urandom_range(hi, lo));
      put(csum);
    end
    ok = legal && (csum == 8'(s % 256));
    @(negedge clk);
    flags("frame_end", ok, !ok, legal ? 6'(len) : 6'd0, 1'b0);
    chk("writes_drained", qa.size() + qb.size(), 0);
  endtask

  task automatic do_restart(input bit coincide, input logic [5:0] bl);
    @(negedge clk);
    restart = 1'b1;
    if (coincide) begin
      in_valid = 1'b1;
      in_byte = 8'hA5;
    end
    @(posedge clk);
    #1 restart = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    flags("after_restart", 1'b0, 1'b0, bl, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] len, csum, jb;
    int s, r;
    #1 rst = 1'b1;
    #1 chk("reset_outputs_a", {a_we, a_mem, a_data, a_bl, a_done, a_err, a_run}, 0);
    chk("reset_outputs_b", {b_we, b_mem, b_data, b_bl, b_done, b_err, b_run}, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) flags("post_reset", 1'b0, 1'b0, 6'd0, 1'b1);
    fd = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, 8'h66, 0, 0);
    idle(3);
    @(negedge clk) flags("sticky_done", 1'b1, 1'b0, 6'd3, 1'b0);
    do_restart(1'b1, 6'd3);
    fd = '{8'h10, 8'h20};
    send_frame(8'd2, 8'h31, 0, 0);
    do_restart(1'b0, 6'd2);
    fd = {};
    send_frame(8'd0, 8'h00, 0, 0);
    do_restart(1'b0, 6'd0);
    send_frame(8'h21, 8'h00, 0, 0);
    do_restart(1'b1, 6'd0);
    put(8'h00);
    idle(1);
    put(8'hFF);
    idle(1);
    put(8'h5A);
    idle(1);
    fd = '{8'h7F};
    send_frame(8'd1, 8'h7F, 1, 1);
    do_restart(1'b0, 6'd1);
    put(8'hA5);
    put(8'h04);
    qa.push_back(16'h0001);
    qb.push_back(16'h1001);
    put(8'h01);
    qa.push_back(16'h0102);
    qb.push_back(16'h1102);
    put(8'h02);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid_data_a", {a_we, a_mem, a_data, a_bl, a_done, a_err, a_run}, 0);
    chk("rst_mid_data_b", {b_we, b_mem, b_data, b_bl, b_done, b_err, b_run}, 0);
    @(negedge clk) rst = 1'b0;
    idle(3);
    @(negedge clk) flags("after_rst_release", 1'b0, 1'b0, 6'd0, 1'b1);
    fd = '{8'hAA, 8'hBB};
    send_frame(8'd2, 8'h65, 0, 2);
    do_restart(1'b0, 6'd2);
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      len = (r == 0) ? 8'd0 : (r == 1) ? 8'(33 + $urandom_range(0, 200)) : 8'($urandom_range(1, 32));
      fd = {};
      s = 0;
      if (len != 8'd0 && len <= 8'd32)
        for (int i = 0; i < int'(len); i++) begin
          fd.push_back(8'($urandom));
          s += int'(fd[i]);
        end
      csum = $urandom_range(0, 1) ? 8'(s % 256) : 8'(s % 256) ^ 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        put(jb);
      end
      send_frame(len, csum, 0, 2);
      do_restart(1'($urandom_range(0, 1)), (len != 8'd0 && len <= 8'd32) ? 6'(len) : 6'd0);
    end
    idle(2);
    chk("final_drained", qa.size() + qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
